// File: rtl/digit_scanner_pkg.sv
// Shared types and limits for the multiplexed digit scanner.
package digit_scanner_pkg;

  localparam int MAX_DIGITS = 8;

  typedef enum logic {
    GAP_S = 1'b0,
    ON_S  = 1'b1
  } state_e;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/digit_scanner_lz_mask.sv
// Leading-zero mask for the scanner (used only when LEADING_ZERO_BLANK_EN is defined).
// mask_o[i]=1 when digit i and every digit above it are zero; digit 0 is never masked.
module lz_mask
  import digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  bcd_t [NUM_DIGITS-1:1] digits_i,
  output logic [NUM_DIGITS-1:0] mask_o
);

  // hi_zero[i]: digits i..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS:1] hi_zero;

  assign hi_zero[NUM_DIGITS] = 1'b1;
  assign mask_o[0]           = 1'b0;

  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
    assign hi_zero[gi] = (digits_i[gi] == 4'd0) && hi_zero[gi+1];
    assign mask_o[gi]  = hi_zero[gi];
  end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed display scanner: GAP (all off) then DWELL (one digit on) per digit.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 100000,
  parameter int GAP        = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              nibble,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int              IW         = $clog2(NUM_DIGITS);
  localparam logic [31:0]     GAP_LAST   = 32'(GAP - 1);
  localparam logic [31:0]     DWELL_LAST = 32'(DWELL - 1);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_e                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]   shadow_q, shadow_d;
  bcd_t [NUM_DIGITS-1:0]   active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    wrap;

  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  bcd_t                    nibble_q, nibble_d;
  logic                    blank_q, blank_d;
  logic                    frame_start_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   lz_blank;

  lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .digits_i (active_d[NUM_DIGITS-1:1]),
    .mask_o   (lz_blank)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      GAP_S: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ON_S;
          cnt_d   = '0;
        end
      end
      ON_S: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = GAP_S;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = GAP_S;
        cnt_d   = '0;
      end
    endcase

    // Active digits only change at the frame boundary, so a frame is never torn.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load && wrap) begin
      shadow_d  = digits_in;
      active_d  = digits_in;
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // Outputs are registered from next-state values so they line up with the state.
    digit_sel_d = (state_d == ON_S) ? (NUM_DIGITS'(1) << idx_d) : '0;
    nibble_d    = active_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
    blank_d     = (state_d == GAP_S) ? 1'b1 : lz_blank[idx_d];
`else
    blank_d     = (state_d == GAP_S);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= GAP_S;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      digit_sel_q   <= '0;
      nibble_q      <= '0;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      digit_sel_q   <= digit_sel_d;
      nibble_q      <= nibble_d;
      blank_q       <= blank_d;
      frame_start_q <= wrap;
    end
  end

  assign digit_sel   = digit_sel_q;
  assign nibble      = nibble_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: frame-level reference model plus literal spot checks.
module tb_digit_scanner;

  localparam int N = 4;
  localparam int D = 3;
  localparam int G = 1;
  localparam int P = N * (G + D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [N-1:0]  digit_sel;
  logic [3:0]    nibble;
  logic          blank;
  logic          frame_start;

  digit_scanner #(
    .NUM_DIGITS (N),
    .DWELL      (D),
    .GAP        (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .load        (load),
    .digit_sel   (digit_sel),
    .nibble      (nibble),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          t = 0;          // cycles since reset release
  logic [15:0] disp = '0;      // digits shown in the current frame
  logic [15:0] nxt_val = '0;   // last value loaded during the current frame
  bit          nxt_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Expected outputs from the frame arithmetic: which digit, GAP or ON, frame boundary.
  task automatic model_check();
    int       pos, d;
    bit       on;
    logic [3:0] exp_sel;
    bit       exp_blank;
    pos     = t % P;
    d       = pos / (G + D);
    on      = (pos % (G + D)) >= G;
    exp_sel = on ? 4'(1 << d) : 4'b0;
`ifdef LEADING_ZERO_BLANK_EN
    exp_blank = on ? (d != 0 && (disp >> (4 * d)) == 16'h0) : 1'b1;
`else
    exp_blank = !on;
`endif
    chk("digit_sel", 32'(digit_sel), 32'(exp_sel));
    chk("blank", 32'(blank), 32'(exp_blank));
    chk("frame_start", 32'(frame_start), 32'(t > 0 && pos == 0));
    if (on) chk("nibble", 32'(nibble), 32'((disp >> (4 * d)) & 16'hF));
  endtask

  // One cycle: check outputs of cycle t, then present this cycle's load.
  task automatic step(input bit do_load, input logic [15:0] val);
    @(negedge clk);
    if (t > 0 && t % P == 0 && nxt_valid) begin
      disp      = nxt_val;
      nxt_valid = 1'b0;
    end
    model_check();
    load = do_load;
    if (do_load) begin
      digits_in = val;
      nxt_valid = 1'b1;
      nxt_val   = val;
    end
    t++;
    $display("cycle t=%0d load=%0b din=%h sel=%b nib=%h blank=%b fs=%b",
             t - 1, do_load, digits_in, digit_sel, nibble, blank, frame_start);
  endtask

  logic [3:0] sel_tab [16];
  logic [3:0] nib_tab [16];

  initial begin
    sel_tab = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t = 0;

    // Reset state, free-running scan, deferred loads and wrap-cycle load
    for (int c = 0; c < 106; c++) begin
      bit dl;
      logic [15:0] v;
      dl = 1'b0;
      v  = '0;
      case (c)
        36:  begin dl = 1'b1; v = 16'h1234; end
        50:  begin dl = 1'b1; v = 16'h1234; end
        55:  begin dl = 1'b1; v = 16'h5678; end
        79:  begin dl = 1'b1; v = 16'h9999; end
        100: begin dl = 1'b1; v = 16'h4321; end
        default: ;
      endcase
      step(dl, v);
      if (c == 0) begin
        chk("reset_nibble", 32'(nibble), 32'h0);
        chk("reset_blank", 32'(blank), 32'h1);
      end
      if (c < 32) begin
        chk("scan_sel", 32'(digit_sel), 32'(sel_tab[c % 16]));
        chk("scan_fs", 32'(frame_start), 32'(c == 16));
      end
      if (c >= 48 && c < 96 && (c % 4) == 1) begin
        nib_tab = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0,
                    4'h2, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        if (c < 64)      chk("load_1234", 32'(nibble), 32'(nib_tab[c - 48 - 1]));
        else if (c < 80) chk("load_5678", 32'(nibble), 32'(4'h8 - 4'((c - 65) / 4)));
        else             chk("load_wrap_9999", 32'(nibble), 32'h9);
      end
    end

    // Asynchronous reset during ON of digit 2 with a load pending
    @(negedge clk);
    chk("pre_rst_sel", 32'(digit_sel), 32'h4);
    load = 1'b0;
    rst  = 1'b1;
    #1;
    chk("async_rst_sel", 32'(digit_sel), 32'h0);
    chk("async_rst_blank", 32'(blank), 32'h1);
    chk("async_rst_nibble", 32'(nibble), 32'h0);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    t = 0;
    disp = '0;
    nxt_valid = 1'b0;

    for (int c = 0; c < 40; c++) begin
      step(1'b0, 16'h0);
      if (c == 17 || c == 29) chk("pending_lost", 32'(nibble), 32'h0);
    end

    // Random loads, often with zero nibbles and BCD values above 9
    for (int c = 0; c < 400; c++) begin
      logic [15:0] v;
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 7) == 0, v);
    end

`ifdef LEADING_ZERO_BLANK_EN
    while (t % P != P - 1) step(1'b0, 16'h0);
    step(1'b1, 16'h0050);
    for (int k = 0; k < P; k++) begin
      step(1'b0, 16'h0);
      if (k % (G + D) == G) chk("lz_0050", 32'(blank), 32'(k / (G + D) >= 2));
    end
    while (t % P != P - 1) step(1'b0, 16'h0);
    step(1'b1, 16'h0000);
    for (int k = 0; k < P; k++) begin
      step(1'b0, 16'h0);
      if (k % (G + D) == G) chk("lz_0000", 32'(blank), 32'(k / (G + D) >= 1));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=timeout expected=finish", t);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter DWELL, default 100000: clock cycles a digit is driven, at least 1.
REQ-003 SHALL have parameter GAP, default 1000: all-off cycles before each digit (anti-ghosting), at least 1.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS: BCD digits; bits [3:0] are digit 0, the least significant.
REQ-007 SHALL have port load, input, 1: single-cycle strobe that captures digits_in.
REQ-008 SHALL have port digit_sel, output, NUM_DIGITS: one-hot, active-high digit enable; all zero during GAP.
REQ-009 SHALL have port nibble, output, 4: current digit value, fed to the seven_segment decoder.
REQ-010 SHALL have port blank, output, 1: segments off when 1.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse when digit 0 enters GAP.

Function
REQ-012 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-013 SHALL run a two-state FSM, GAP_S and ON_S, driven by a 32-bit cycle counter and a digit index.
REQ-014 GAP_S: SHALL hold for GAP cycles with digit_sel=0 and blank=1, then go to ON_S.
REQ-015 ON_S: SHALL hold for DWELL cycles with digit_sel[index]=1 and nibble=active[index]; blank=0 except as set by REQ-024.
REQ-016 End of ON_S: SHALL increment the index, wrapping NUM_DIGITS-1 to 0, and return to GAP_S.
REQ-017 Frame period SHALL be exactly NUM_DIGITS*(GAP+DWELL) cycles.
REQ-018 load SHALL copy digits_in into a shadow register and set pending; with several loads in one frame, the last wins.
REQ-019 At the index wrap to 0, if pending is set, SHALL copy shadow to active and clear pending, in the same edge that asserts frame_start.
REQ-020 A load in the wrap cycle SHALL go straight to active and leave pending clear; displayed digits SHALL never change mid-frame.
REQ-021 BCD values 10..15 SHALL pass through unchanged; the decoder handles them.

Reset
REQ-022 On rst: state=GAP_S, index=0, counter=0, digit_sel=0, blank=1, nibble=0, frame_start=0, shadow=0, active=0, pending=0.
REQ-023 Reset mid-frame SHALL abort immediately, discard any pending load, and restart with a full GAP; no frame_start on the first frame after reset.

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined: in ON_S, blank=1 for any zero digit above the most significant nonzero active digit; digit 0 is never blanked (value 0 shows one "0"). Without it: blank=0 throughout ON_S.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef, the BCD nibble typedef and the MAX_DIGITS=8 constant.
REQ-026 The leading-zero mask SHALL be a sub-module, lz_mask (combinational, NUM_DIGITS wide), instantiated only under LEADING_ZERO_BLANK_EN.

Verification
(Bench parameters: NUM_DIGITS=4, DWELL=3, GAP=1; frame period = 16 cycles.)
REQ-027 Release reset, then run 32 cycles: digit_sel goes 0,0001x3,0,0010x3,0,0100x3,0,1000x3, repeating; frame_start at cycle 16 only.
REQ-028 Load 0x1234 mid-frame: nibbles stay 0 until the wrap, then read 4,3,2,1; a second load of 0x5678 in the same frame gives 8,7,6,5 instead.
REQ-029 Load 0x9999 in the exact wrap cycle: that frame shows 9,9,9,9 and pending=0 afterwards.
REQ-030 Assert rst during ON_S of digit 2: all outputs take reset values asynchronously and the pending load is lost.
REQ-031 With LEADING_ZERO_BLANK_EN, active=0x0050: blank=0 on digits 0 and 1, blank=1 on digits 2 and 3; with active=0x0000, only digit 0 is unblanked.
